// File: rtl/soc_system_pio_write_arbiter.sv
// Two-requester arbiter serialising 3-bit writes onto an Avalon-MM PIO slave.
// Round-robin on ties, one write cycle, then HOLDOFF forced idle cycles.
module soc_system_pio_write_arbiter #(
  parameter int unsigned HOLDOFF     = 4,
  parameter logic [2:0]  RESET_VALUE = 3'b111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_data,
  output logic        req1_ready,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic [2:0]  shadow_data,
  output logic        busy,
  output logic [15:0] write_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST =
    (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  state_t     state;
  logic       last_grant;
  logic [7:0] hold_cnt;
  logic [2:0] lat_data;
  logic [2:0] grant_data;
  logic       idle;

  assign idle        = (state == IDLE);
  assign busy        = ~idle;
  assign pio_address = 2'b00;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_data = req0_data;
    if (idle) begin
      unique case (1'b1)
        req0_valid && (!req1_valid || last_grant): begin
          req0_ready = 1'b1;
          grant_data = req0_data;
        end
        req1_valid && (!req0_valid || !last_grant): begin
          req1_ready = 1'b1;
          grant_data = req1_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      hold_cnt       <= 8'd0;
      lat_data       <= 3'b000;
      shadow_data    <= RESET_VALUE;
      write_count    <= 16'd0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            lat_data       <= grant_data;
            last_grant     <= req1_ready;
            state          <= WRITE;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {29'd0, grant_data};
          end
        end
        WRITE: begin
          shadow_data    <= lat_data;
          write_count    <= write_count + 16'd1;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          pio_writedata  <= 32'd0;
          if (HOLDOFF == 0) begin
            state <= IDLE;
          end else begin
            state    <= HOLD;
            hold_cnt <= HOLD_LAST;
          end
        end
        HOLD: begin
          if (hold_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
